// File: rtl/pulpino_qsys_pkg.sv
// Shared definitions for the DE10-Nano bring-up test system: FSM state
// encoding, LEDR bit positions, boot/timer/IRQ constants and the helper
// that turns the period switches into a timer compare value.
package pulpino_qsys_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2,
        ST_IRQ   = 2'd3
    } state_t;

    // Boot and setup sequence
    localparam logic [31:0] BOOT_ADDR    = 32'h0000_8000;
    localparam int          SETUP_CYCLES = 256;
    // pc value during the final setup fetch; SETUP exits on that cycle.
    localparam logic [31:0] SETUP_LAST_PC = BOOT_ADDR + 32'(4 * (SETUP_CYCLES - 1));

    // Interval timer
    localparam int TIMER_PERIOD = 256;
    localparam int PERIOD_SCALE = 16;
    localparam int PERIOD_SEL_W = 6;
    // Wide enough for 63 * 16 = 1008.
    localparam int COMPARE_W    = 10;

    // Interrupt handler
    localparam int                 IRQ_CYCLES = 4;
    localparam int                 IRQ_CNT_W  = $clog2(IRQ_CYCLES);
    localparam logic [IRQ_CNT_W-1:0] IRQ_LAST = IRQ_CNT_W'(IRQ_CYCLES - 1);

    // LEDR bit positions
    localparam int LED_SW_LSB      = 0;
    localparam int LED_SW_W        = 4;
    localparam int LED_SETUP_DONE  = 4;
    localparam int LED_IRQ_ACTIVE  = 5;
    localparam int LED_IRQ_CNT_LSB = 6;
    localparam int IRQ_COUNT_W     = 4;

    // A zero selection falls back to the default period.
    function automatic logic [COMPARE_W-1:0] calc_compare(input logic [PERIOD_SEL_W-1:0] sel);
        if (sel == '0) begin
            return COMPARE_W'(TIMER_PERIOD);
        end
        return COMPARE_W'(sel) * COMPARE_W'(PERIOD_SCALE);
    endfunction

endpackage

// File: rtl/qsys_timer.sv
// Programmable interval timer.
// Ports:
//   i_clk        - board clock
//   i_rst        - synchronous active-high reset
//   i_load       - latch the compare value from i_period_sel
//   i_period_sel - period selection (0 = default period, else sel * scale)
//   i_count_en   - count while the system is running or servicing an IRQ
//   i_freeze_n   - low holds the counter at its current value
//   o_hit        - one-cycle pulse on the cycle the counter wraps
module qsys_timer
    import pulpino_qsys_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [PERIOD_SEL_W-1:0] i_period_sel,
    input  logic                    i_count_en,
    input  logic                    i_freeze_n,
    output logic                    o_hit
);

    logic [COMPARE_W-1:0] r_count;
    logic [COMPARE_W-1:0] r_compare;
    logic                 w_advance;
    logic                 w_wrap;

    assign w_advance = i_count_en & i_freeze_n;
    assign w_wrap    = (r_count == r_compare - COMPARE_W'(1));
    // A frozen counter sitting on the wrap value does not hit.
    assign o_hit     = w_advance & w_wrap;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_compare <= COMPARE_W'(TIMER_PERIOD);
        end else begin
            if (i_load) begin
                r_compare <= calc_compare(i_period_sel);
            end
            if (w_advance) begin
                r_count <= w_wrap ? '0 : r_count + COMPARE_W'(1);
            end
        end
    end

endmodule

// File: rtl/pulpino_qsys_test_sys.sv
// Board-level bring-up test system: boot/setup sequencer, interval timer
// with interrupt, software interrupt from KEY[2], and LED status mapping.
// Ports:
//   CLOCK_50 - 50 MHz board clock, rising edge
//   KEY[3:0] - push-buttons, active-low: [0] reset, [1] timer freeze,
//              [2] software interrupt (falling edge), [3] unused
//   SW[9:0]  - [3:0] mirrored to LEDs after setup, [9:4] timer period select
//   LEDR[9:0]- registered status: [3:0] switches, [4] setup_done,
//              [5] in IRQ, [9:6] irq_count
module pulpino_qsys_test_sys
    import pulpino_qsys_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);

    logic                   r_rst;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [31:0]            r_pc;
    logic                   r_setup_done;
    logic                   r_irq_pending;
    logic [IRQ_COUNT_W-1:0] r_irq_count;
    logic [IRQ_CNT_W-1:0]   r_irq_cyc;
    logic [1:0]             r_key2_sync;
    logic                   r_key2_prev;
    logic [9:0]             r_ledr;

    logic w_setup_last;
    logic w_irq_last;
    logic w_sw_irq;
    logic w_timer_hit;
    logic w_setup_exit;
    logic w_service;
    logic w_timer_en;
    logic w_in_irq;
    logic w_unused_key3;

    assign w_unused_key3 = KEY[3];

    // NOTE: the reset button is registered once and then used as a plain
    // synchronous reset; r_rst itself has no reset since it is the source.
    always_ff @(posedge CLOCK_50) begin
        r_rst <= ~KEY[0];
    end

    assign w_setup_last = (r_pc == SETUP_LAST_PC);
    assign w_irq_last   = (r_irq_cyc == IRQ_LAST);
    assign w_sw_irq     = r_key2_prev & ~r_key2_sync[1];

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (r_rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    // NOTE: every always_comb output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_SETUP;
            ST_SETUP: if (w_setup_last)  w_state_nxt = ST_RUN;
            ST_RUN:   if (r_irq_pending) w_state_nxt = ST_IRQ;
            ST_IRQ:   if (w_irq_last)    w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_BOOT;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_setup_exit = 1'b0;
        w_service    = 1'b0;
        w_timer_en   = 1'b0;
        w_in_irq     = 1'b0;
        case (r_state)
            ST_SETUP: w_setup_exit = w_setup_last;
            ST_RUN: begin
                w_timer_en = 1'b1;
                w_service  = r_irq_pending;
            end
            ST_IRQ: begin
                w_timer_en = 1'b1;
                w_in_irq   = 1'b1;
            end
            default: ;
        endcase
    end

    qsys_timer u_timer (
        .i_clk        (CLOCK_50),
        .i_rst        (r_rst),
        .i_load       (w_setup_exit),
        .i_period_sel (SW[9:4]),
        .i_count_en   (w_timer_en),
        .i_freeze_n   (KEY[1]),
        .o_hit        (w_timer_hit)
    );

    always_ff @(posedge CLOCK_50) begin
        if (r_rst) begin
            r_pc          <= BOOT_ADDR;
            r_setup_done  <= 1'b0;
            r_irq_pending <= 1'b0;
            r_irq_count   <= '0;
            r_irq_cyc     <= '0;
            // Idle-high so leaving reset with KEY[2] released is not an edge.
            r_key2_sync   <= 2'b11;
            r_key2_prev   <= 1'b1;
        end else begin
            r_key2_sync <= {r_key2_sync[0], KEY[2]};
            r_key2_prev <= r_key2_sync[1];

            if (r_state == ST_SETUP) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_setup_exit) begin
                r_setup_done <= 1'b1;
            end

            // A single pending bit: coincident or repeated events collapse
            // into one interrupt. A new event wins over the service clear.
            if (w_timer_hit || w_sw_irq) begin
                r_irq_pending <= 1'b1;
            end else if (w_service) begin
                r_irq_pending <= 1'b0;
            end

            if (w_service) begin
                r_irq_count <= r_irq_count + IRQ_COUNT_W'(1);
            end

            r_irq_cyc <= w_in_irq ? r_irq_cyc + IRQ_CNT_W'(1) : '0;
        end
    end

    // LED register: reflects the state one cycle after it changes.
    always_ff @(posedge CLOCK_50) begin
        if (r_rst) begin
            r_ledr <= '0;
        end else begin
            r_ledr[LED_SW_LSB +: LED_SW_W]          <= r_setup_done ? SW[3:0] : '0;
            r_ledr[LED_SETUP_DONE]                  <= r_setup_done;
            r_ledr[LED_IRQ_ACTIVE]                  <= (r_state == ST_IRQ);
            r_ledr[LED_IRQ_CNT_LSB +: IRQ_COUNT_W]  <= r_irq_count;
        end
    end

    assign LEDR = r_ledr;

endmodule

// File: tb/tb_pulpino_qsys_test_sys.sv
// Self-checking bench for pulpino_qsys_test_sys. Cycle numbers are counted
// in rising edges from the negedge at which KEY[0] is released. Expected
// interrupts (count and LEDR[5] rise cycle) are pushed to a scoreboard when
// the stimulus is set up and popped when the DUT raises LEDR[5].
module tb_pulpino_qsys_test_sys;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;

    int cyc = 0;
    int base = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int count;
        int rise;
    } exp_t;

    exp_t sb[$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    pulpino_qsys_test_sys dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .LEDR     (ledr)
    );

    task automatic expect_irq(input int count, input int rise);
        exp_t e;
        e.count = count;
        e.rise  = rise;
        sb.push_back(e);
    endtask

    // Waits for the next LEDR[5] rise and compares it with the scoreboard head.
    task automatic wait_irq(input string name, input int budget, input bit check_width);
        exp_t e;
        int   n = 0;
        int   width = 0;
        bit   seen = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s_sb: scoreboard empty", name);
            failures++;
            return;
        end
        e = sb.pop_front();
        while (n < budget && !seen) begin
            @(negedge clk);
            n++;
            if (ledr[5]) seen = 1'b1;
        end
        if (!seen) begin
            $display("FAIL %s_timeout: no LEDR[5] within %0d cycles, expected rise at %0d", name, budget, e.rise);
            failures++;
            return;
        end
        checks++;
        if (cyc - base !== e.rise) begin
            $display("FAIL %s_time: LEDR[5] rose at cycle %0d, expected %0d", name, cyc - base, e.rise);
            failures++;
        end
        checks++;
        if (ledr[9:6] !== 4'(e.count)) begin
            $display("FAIL %s_count: LEDR[9:6]=%0d, expected %0d", name, ledr[9:6], e.count);
            failures++;
        end
        if (check_width) begin
            while (ledr[5] && width < 20) begin
                width++;
                @(negedge clk);
            end
            checks++;
            if (width !== 4) begin
                $display("FAIL %s_width: LEDR[5] high %0d cycles, expected 4", name, width);
                failures++;
            end
        end
    endtask

    task automatic do_reset(input logic [9:0] sw_val);
        @(negedge clk);
        key = 4'b1110;
        sw  = sw_val;
        repeat (5) @(negedge clk);
        checks++;
        if (ledr !== 10'd0) begin
            $display("FAIL reset_leds: LEDR=%b during reset, expected 0", ledr);
            failures++;
        end
        key[0] = 1'b1;
        base   = cyc;
        sb.delete();
    endtask

    task automatic check_boot(input string name);
        int n = 0;
        bit seen = 1'b0;
        bit bad = 1'b0;
        while (n < 400 && !seen) begin
            @(negedge clk);
            n++;
            if (ledr[4]) seen = 1'b1;
            else if (ledr !== 10'd0) bad = 1'b1;
        end
        checks++;
        if (!seen) begin
            $display("FAIL %s_timeout: LEDR[4] not set within 400 cycles", name);
            failures++;
            return;
        end
        checks++;
        if (bad) begin
            $display("FAIL %s_setup_quiet: LEDR nonzero before setup_done", name);
            failures++;
        end
        checks++;
        if (cyc - base !== 259) begin
            $display("FAIL %s_setup_time: LEDR[4] at cycle %0d, expected 259", name, cyc - base);
            failures++;
        end
        checks++;
        if (ledr[3:0] !== sw[3:0]) begin
            $display("FAIL %s_mirror: LEDR[3:0]=%b, expected %b", name, ledr[3:0], sw[3:0]);
            failures++;
        end
        checks++;
        if (ledr[9:5] !== 5'd0) begin
            $display("FAIL %s_status: LEDR[9:5]=%b, expected 0", name, ledr[9:5]);
            failures++;
        end
    endtask

    task automatic test_reset_and_boot;
        do_reset(10'd0);
        check_boot("boot");
        // RUN at 258, first hit at 258+256, IRQ one later, LED one later.
        expect_irq(1, 516);
        wait_irq("first_irq", 600, 1'b1);
    endtask

    task automatic test_led_mirror;
        @(negedge clk);
        sw[3:0] = 4'b1010;
        @(negedge clk);
        checks++;
        if (ledr[3:0] !== 4'b1010) begin
            $display("FAIL mirror_1010: LEDR[3:0]=%b, expected 1010", ledr[3:0]);
            failures++;
        end
        // Changing the period switches after setup must not affect the timer.
        sw = {6'd3, 4'b0101};
        @(negedge clk);
        checks++;
        if (ledr[3:0] !== 4'b0101) begin
            $display("FAIL mirror_0101: LEDR[3:0]=%b, expected 0101", ledr[3:0]);
            failures++;
        end
    endtask

    task automatic test_freeze;
        int f = 300;
        bit bad = 1'b0;
        @(negedge clk);
        key[1] = 1'b0;
        repeat (f) begin
            @(negedge clk);
            if (ledr[5] || ledr[9:6] !== 4'd1) bad = 1'b1;
        end
        key[1] = 1'b1;
        checks++;
        if (bad) begin
            $display("FAIL freeze_quiet: interrupt or count change while frozen, LEDR=%b", ledr);
            failures++;
        end
        // Second hit would be at 770; the freeze delays it by f cycles.
        expect_irq(2, 772 + f);
        wait_irq("after_freeze", 600, 1'b1);
    endtask

    task automatic test_sw_irq;
        int c0;
        @(negedge clk);
        c0 = cyc - base;
        key[2] = 1'b0;
        // Sampled at c0+1, two sync flops, pending, IRQ, LED.
        expect_irq(3, c0 + 5);
        repeat (3) @(negedge clk);
        key[2] = 1'b1;
        wait_irq("sw_irq", 20, 1'b1);
    endtask

    task automatic test_coincident;
        int n = 0;
        bit extra = 1'b0;
        // Timer hit at 1070 + 256 = 1326; align the software edge with it.
        while (cyc - base < 1323) @(negedge clk);
        key[2] = 1'b0;
        expect_irq(4, 1328);
        repeat (3) @(negedge clk);
        key[2] = 1'b1;
        wait_irq("coincident", 20, 1'b1);
        while (n < 150) begin
            @(negedge clk);
            n++;
            if (ledr[5]) extra = 1'b1;
        end
        checks++;
        if (extra || ledr[9:6] !== 4'd4) begin
            $display("FAIL coincident_single: extra interrupt or count %0d, expected 4", ledr[9:6]);
            failures++;
        end
    endtask

    task automatic test_fast_period;
        do_reset({6'd1, 4'b1010});
        check_boot("fast_boot");
        for (int k = 1; k <= 17; k++) begin
            expect_irq(k % 16, 276 + 16 * (k - 1));
        end
        for (int k = 1; k <= 17; k++) begin
            wait_irq($sformatf("fast_irq%0d", k), 40, 1'b1);
        end
    endtask

    task automatic test_reset_in_irq;
        expect_irq(2, 276 + 16 * 17);
        wait_irq("pre_reset_irq", 40, 1'b0);
        key[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ledr !== 10'd0) begin
            $display("FAIL reset_in_irq: LEDR=%b, expected 0", ledr);
            failures++;
        end
        do_reset(10'd0);
        check_boot("reboot");
        expect_irq(1, 516);
        wait_irq("reboot_irq", 600, 1'b1);
    endtask

    initial begin
        key = 4'b1110;
        sw  = 10'd0;
        test_reset_and_boot();
        test_led_mirror();
        test_freeze();
        test_sw_irq();
        test_coincident();
        test_fast_period();
        test_reset_in_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
